// File: rtl/beta_fetch_unit.sv
// beta_fetch_unit: PC register and instruction-fetch stage of the unpipelined Beta.
// Holds the PC, runs the request/ready handshake with instruction memory,
// captures the fetched word into IR and derives the PC4 / PC4SXT operands.
module beta_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h80000000,
  parameter logic [31:0] ILLOP_VECTOR = 32'h80000004,
  parameter logic [31:0] XADR_VECTOR  = 32'h80000008,
  parameter int          TIMEOUT      = 16,
  parameter int          CNT_W        = 5
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] PC_NEXT,
  input  logic        PC_ADV,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_RDY,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] IR,
  output logic        IR_VALID,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic [31:0] PC4SXT,
  input  logic        IRQ,
  output logic        IRQ_PENDING,
  output logic        FETCH_FAULT
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  // Last count value of a fetch window before it is declared timed out.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_q, irq_d;
  logic             fault_q, fault_d;
  logic             adv_acc;
  logic             irq_clr;

  // Bit 31 is the supervisor bit and is carried from the PC, never produced by a carry.
  function automatic logic [31:0] pc4_f(input logic [31:0] pc);
    logic [30:0] sum;
    sum = pc[30:0] + 31'd4;
    return {pc[31], sum};
  endfunction

  // Branch target: PC4 plus the sign-extended word offset, wrapping in the low 31 bits.
  function automatic logic [31:0] pc4sxt_f(input logic [31:0] pc4, input logic [15:0] lit);
    logic signed [30:0] off;
    logic [30:0]        sum;
    off = {{13{lit[15]}}, lit, 2'b00};
    sum = pc4[30:0] + off;
    return {pc4[31], sum};
  endfunction

  assign adv_acc = (state_q == S_HOLD) && PC_ADV;
  assign irq_clr = adv_acc && (PC_NEXT == XADR_VECTOR);

  // Next-state logic for the fetch FSM, PC, IR, timeout count and IRQ latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    fault_d = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (IMEM_RDY) begin
          // A ready on the final cycle of the window still wins over the timeout.
          ir_d    = IMEM_RDATA;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = 1'b1;
          pc_d    = ILLOP_VECTOR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HOLD: begin
        if (PC_ADV) begin
          pc_d    = {PC_NEXT[31:2], 2'b00};
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
    // A new request in the same cycle as the clearing jump keeps the latch set.
    irq_d = IRQ | (irq_q & ~irq_clr);
  end

  // State registers; reset aborts any fetch in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      ir_q    <= '0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
      fault_q <= fault_d;
    end
  end

  assign IMEM_REQ    = (state_q == S_FETCH);
  assign IMEM_ADDR   = pc_q;
  assign IR          = ir_q;
  assign IR_VALID    = (state_q == S_HOLD);
  assign PC          = pc_q;
  assign PC4         = pc4_f(pc_q);
  assign PC4SXT      = pc4sxt_f(PC4, ir_q[15:0]);
  assign IRQ_PENDING = irq_q & ~pc_q[31];
  assign FETCH_FAULT = fault_q;

endmodule

// File: tb/tb_beta_fetch_unit.sv
// Self-checking bench for beta_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_beta_fetch_unit;

  localparam logic [31:0] RV = 32'h80000000;
  localparam logic [31:0] IV = 32'h80000004;
  localparam logic [31:0] XV = 32'h80000008;
  localparam int          TO = 16;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] PC_NEXT = '0;
  logic        PC_ADV = 1'b0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_RDY = 1'b0;
  logic [31:0] IMEM_RDATA = '0;
  logic [31:0] IR;
  logic        IR_VALID;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic [31:0] PC4SXT;
  logic        IRQ = 1'b0;
  logic        IRQ_PENDING;
  logic        FETCH_FAULT;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  beta_fetch_unit dut (
    .CLK(CLK), .RESET_N(RESET_N), .PC_NEXT(PC_NEXT), .PC_ADV(PC_ADV),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDY(IMEM_RDY),
    .IMEM_RDATA(IMEM_RDATA), .IR(IR), .IR_VALID(IR_VALID), .PC(PC),
    .PC4(PC4), .PC4SXT(PC4SXT), .IRQ(IRQ), .IRQ_PENDING(IRQ_PENDING),
    .FETCH_FAULT(FETCH_FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_BOOT, M_WAIT_MEM, M_HOLDING} mphase_t;
  mphase_t     m_phase = M_BOOT;
  logic [31:0] m_pc    = RV;
  logic [31:0] m_ir    = '0;
  int          m_waited = 0;   // fetch cycles already spent without a ready
  bit          m_irq   = 1'b0;
  bit          m_fault = 1'b0;

  function automatic logic [31:0] ref_pc4(input logic [31:0] pc);
    longint low;
    low = longint'(pc & 32'h7FFFFFFF);
    low = (low + 4) % (64'sd1 << 31);
    return (pc & 32'h80000000) | 32'(low);
  endfunction

  function automatic logic [31:0] ref_pc4sxt(input logic [31:0] pc, input logic [31:0] ir);
    longint base, off, low;
    base = longint'(ref_pc4(pc) & 32'h7FFFFFFF);
    off  = longint'($signed(ir[15:0])) * 4;
    low  = (base + off + (64'sd1 << 31)) % (64'sd1 << 31);
    return (pc & 32'h80000000) | 32'(low);
  endfunction

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_phase = M_BOOT; m_pc = RV; m_ir = '0; m_waited = 0; m_irq = 1'b0; m_fault = 1'b0;
    end else begin
      bit jump_to_xadr;
      jump_to_xadr = (m_phase == M_HOLDING) && PC_ADV && (PC_NEXT == XV);
      m_fault = 1'b0;
      if (m_phase == M_BOOT) begin
        m_phase = M_WAIT_MEM; m_waited = 0;
      end else if (m_phase == M_WAIT_MEM) begin
        if (IMEM_RDY) begin
          m_ir = IMEM_RDATA; m_phase = M_HOLDING; m_waited = 0;
        end else if (m_waited + 1 == TO) begin
          m_fault = 1'b1; m_pc = IV; m_waited = 0;
        end else begin
          m_waited++;
        end
      end else if (PC_ADV) begin
        m_pc = PC_NEXT & ~32'd3; m_phase = M_WAIT_MEM; m_waited = 0;
      end
      if (IRQ) m_irq = 1'b1;
      else if (jump_to_xadr) m_irq = 1'b0;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("req",      {31'd0, IMEM_REQ},    {31'd0, m_phase == M_WAIT_MEM});
      chk("addr",     IMEM_ADDR,            m_pc);
      chk("pc",       PC,                   m_pc);
      chk("ir",       IR,                   m_ir);
      chk("ir_valid", {31'd0, IR_VALID},    {31'd0, m_phase == M_HOLDING});
      chk("pc4",      PC4,                  ref_pc4(m_pc));
      chk("pc4sxt",   PC4SXT,               ref_pc4sxt(m_pc, m_ir));
      chk("irq_pend", {31'd0, IRQ_PENDING}, {31'd0, m_irq && !m_pc[31]});
      chk("fault",    {31'd0, FETCH_FAULT}, {31'd0, m_fault});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge CLK);
    #1;
  endtask

  task automatic fetch_word(input logic [31:0] w);
    IMEM_RDY = 1'b1; IMEM_RDATA = w;
    cyc();
    IMEM_RDY = 1'b0;
  endtask

  task automatic advance(input logic [31:0] nxt);
    PC_ADV = 1'b1; PC_NEXT = nxt;
    cyc();
    PC_ADV = 1'b0;
  endtask

  initial begin
    int rdy_div;
    repeat (2) cyc();
    chk_en = 1'b1;
    chk("rst_pc",    PC, 32'h80000000);
    chk("rst_ir",    IR, 32'h0);
    chk("rst_valid", {31'd0, IR_VALID},    32'd0);
    chk("rst_req",   {31'd0, IMEM_REQ},    32'd0);
    chk("rst_fault", {31'd0, FETCH_FAULT}, 32'd0);

    // First fetch, ready three cycles after the request.
    RESET_N = 1'b1;
    cyc();
    chk("boot_req",  {31'd0, IMEM_REQ}, 32'd1);
    chk("boot_addr", IMEM_ADDR, 32'h80000000);
    repeat (2) cyc();
    IMEM_RDY = 1'b1; IMEM_RDATA = 32'hC3E00005;
    chk("valid_before", {31'd0, IR_VALID}, 32'd0);
    cyc();
    IMEM_RDY = 1'b0;
    chk("valid_after", {31'd0, IR_VALID}, 32'd1);
    chk("ir_first",    IR,  32'hC3E00005);
    chk("pc4_first",   PC4, 32'h80000004);

    // Branch operand and PC advance with low bits discarded.
    advance(32'h80000010);
    fetch_word(32'h0000FFFE);
    chk("pc4sxt_neg", PC4SXT, 32'h8000000C);
    advance(32'h00000103);
    chk("adv_pc",  PC, 32'h00000100);
    chk("adv_req", {31'd0, IMEM_REQ}, 32'd1);

    // Timeout after sixteen cycles without ready.
    repeat (15) cyc();
    chk("no_fault_early", {31'd0, FETCH_FAULT}, 32'd0);
    cyc();
    chk("fault_pulse", {31'd0, FETCH_FAULT}, 32'd1);
    chk("fault_pc",    PC, 32'h80000004);
    chk("fault_req",   {31'd0, IMEM_REQ}, 32'd1);
    cyc();
    chk("fault_once",  {31'd0, FETCH_FAULT}, 32'd0);
    // Ready on the sixteenth cycle of the new window beats the timeout.
    repeat (14) cyc();
    fetch_word(32'h12345678);
    chk("rdy_at_limit_fault", {31'd0, FETCH_FAULT}, 32'd0);
    chk("rdy_at_limit_valid", {31'd0, IR_VALID},    32'd1);

    // Interrupt latch, supervisor masking and clear on the XADR jump.
    advance(32'h00000200);
    IRQ = 1'b1; cyc(); IRQ = 1'b0;
    chk("irq_user", {31'd0, IRQ_PENDING}, 32'd1);
    fetch_word(32'h0);
    advance(32'h80000040);
    chk("irq_super", {31'd0, IRQ_PENDING}, 32'd0);
    fetch_word(32'h0);
    advance(32'h80000008);
    chk("xadr_pc", PC, 32'h80000008);
    fetch_word(32'h0);
    advance(32'h00000300);
    chk("irq_cleared", {31'd0, IRQ_PENDING}, 32'd0);

    // PC4 wrap in the low 31 bits, supervisor bit preserved.
    fetch_word(32'h0);
    advance(32'h7FFFFFFF);
    chk("wrap_user", PC4, 32'h00000000);
    fetch_word(32'h0);
    advance(32'hFFFFFFFC);
    chk("wrap_super", PC4, 32'h80000000);

    // Asynchronous reset during a fetch with ready arriving the same cycle.
    IMEM_RDY = 1'b1; IMEM_RDATA = 32'hDEADBEEF; RESET_N = 1'b0;
    #1;
    chk("arst_pc",    PC, 32'h80000000);
    chk("arst_ir",    IR, 32'h0);
    chk("arst_req",   {31'd0, IMEM_REQ}, 32'd0);
    chk("arst_valid", {31'd0, IR_VALID}, 32'd0);
    cyc();
    IMEM_RDY = 1'b0;
    chk("arst_ir_held", IR, 32'h0);
    RESET_N = 1'b1;

    // Randomized traffic; ready rate alternates so both timeouts and fetches occur.
    for (int i = 0; i < 4000; i++) begin
      rdy_div = ((i / 400) % 2 == 0) ? 3 : 40;
      IMEM_RDY   = ($urandom % rdy_div) == 0;
      IMEM_RDATA = $urandom;
      PC_ADV     = ($urandom % 3) == 0;
      case ($urandom % 4)
        0:       PC_NEXT = XV;
        1:       PC_NEXT = $urandom & 32'h7FFFFFFF;
        default: PC_NEXT = $urandom;
      endcase
      IRQ     = ($urandom % 16) == 0;
      RESET_N = ($urandom % 600) != 0;
      cyc();
    end
    RESET_N = 1'b1; IMEM_RDY = 1'b0; PC_ADV = 1'b0; IRQ = 1'b0;
    cyc();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
